iob_cache_be_arbiter: RTL and testbench
=======================================

Name: iob_cache_be_arbiter

Overview:
- Round-robin arbiter that shares one back-end native memory port between N cache back-end masters, for example an I-cache and a D-cache in front of one DDR controller.
- Grants are sticky, so a cache keeps the port across a multi-word line replacement or a write-through buffer drain.
- An optional burst cap forces handover when other caches are waiting.
- Sits between the be_* ports of the caches and the memory controller or next-level cache.

Parameters:
- N_MASTERS, 2, number of requesting caches (>=2).
- BE_ADDR_W, 24, back-end byte address width.
- BE_DATA_W, 32, back-end data width; strobe width is BE_DATA_W/8.
- MAX_XFERS, 8, acked transfers per grant before a forced release when others are pending; 0 = unlimited.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  synchronous, active-high reset.
- s_req  in  N_MASTERS  per-master request, held until acked.
- s_addr  in  N_MASTERS*BE_ADDR_W  packed addresses, master i at [i*BE_ADDR_W +: BE_ADDR_W].
- s_wdata  in  N_MASTERS*BE_DATA_W  packed write data.
- s_wstrb  in  N_MASTERS*BE_DATA_W/8  packed strobes; all-zero = read.
- s_rdata  out  N_MASTERS*BE_DATA_W  m_rdata replicated into every slot.
- s_ack  out  N_MASTERS  per-master acknowledge.
- m_req  out  1  request to memory.
- m_addr  out  BE_ADDR_W  address to memory.
- m_wdata  out  BE_DATA_W  write data to memory.
- m_wstrb  out  BE_DATA_W/8  strobe to memory.
- m_rdata  in  BE_DATA_W  read data, valid with m_ack.
- m_ack  in  1  memory acknowledge; only meaningful while m_req=1.

Behaviour:
- Clock and reset: one clock (clk_i), synchronous active-high reset rst_i.
- Registered state:
  - state ∈ {IDLE, BUSY}
  - grant (clog2(N) bits)
  - last (clog2(N) bits)
  - cnt (clog2(MAX_XFERS+1) bits)
- Reset values: state=IDLE, grant=0, last=N_MASTERS-1 (master 0 wins first), cnt=0.
- Outputs during and after reset: m_req=0, s_ack=0. m_addr, m_wdata and m_wstrb are driven from the grant slot (0 after reset); m_wstrb is 0 whenever state=IDLE.
- IDLE:
  - If |s_req, pick the first requesting index searching last+1, last+2, … modulo N.
  - Load grant with that index, clear cnt, go to BUSY.
  - Nothing is forwarded in IDLE. Latency from s_req rise to m_req is exactly 1 cycle.
- BUSY, combinational forwarding:
  - m_req = s_req[grant].
  - m_addr, m_wdata, m_wstrb are taken from slot grant.
  - s_ack[grant] = m_ack; all other s_ack bits are 0.
- BUSY, on m_ack: cnt increments.
- BUSY, release conditions. Either one sends state to IDLE and sets last=grant:
  - (a) s_req[grant]=0. The owner is idle and no transfer is outstanding, since the native protocol holds req until ack.
  - (b) MAX_XFERS!=0 and m_ack and cnt==MAX_XFERS-1 and any other s_req bit is set. This is a forced release on the capping ack.
- Cap not reached-out: when the cap is reached but no other master is requesting, the owner keeps the grant and cnt saturates at MAX_XFERS.
- After release:
  - One IDLE bubble cycle always occurs between grants, including when the same master re-wins.
  - A forced-out owner that still holds s_req gets no ack and waits.
  - Its req must remain stable; it re-competes normally and is lowest priority in the next round.
- Simultaneous events:
  - Owner drops req in the same cycle another raises req: release, then arbitrate in IDLE next cycle.
  - m_ack in the same cycle as a forced release: the ack is delivered to the owner; the release takes effect next cycle.
- Fairness: with all N requesting continuously and a cap set, grants rotate 0,1,…,N-1,0.
- Reset mid-operation: state returns to IDLE and m_req drops the same clock. Any in-flight memory transaction is the memory's responsibility. No ack is routed after reset.
- Invariants the verification engineer must check:
  - s_ack is one-hot or zero.
  - s_ack[i] implies the grant is i.
  - m_req=0 in IDLE.

Test Plan:
1. N=2, MAX_XFERS=8, only master 1 reads addr 0x100; memory acks 2 cycles after m_req → m_req rises 1 cycle after s_req[1]; m_addr=0x100; s_ack=2'b10 in the ack cycle; s_rdata slot 1 = m_rdata (0xDEADBEEF).
2. Both masters request in the same cycle right after reset → master 0 is served first. When s_req[0] drops, 1 IDLE cycle follows, then grant=1.
3. Master 0 holds req for a 4-word line fill (addr 0x200, 0x204, 0x208, 0x20C) while master 1 requests from the 2nd word → all 4 words complete with no interleaving (4 < MAX_XFERS); master 1 is served after.
4. MAX_XFERS=2, master 0 requests 5 words, master 1 requests 1 word, memory acks every cycle → ack sequence is M0, M0, M1, M0, M0, M0, with an IDLE bubble at each handover.
5. MAX_XFERS=2, only master 0 requests 6 words → no forced release; 6 acks are delivered; cnt saturates at 2.
6. Assert rst_i while grant=1 and m_req=1 → the next cycle m_req=0, s_ack=0, state=IDLE; after reset release, master 0 wins a simultaneous request.

Source files
------------

// File: rtl/iob_cache_be_arbiter.sv
// -----------------------------------------------------------------------------
// iob_cache_be_arbiter
//
// Round-robin arbiter sharing one back-end native memory port between
// N_MASTERS cache back ends (e.g. I-cache + D-cache in front of one DDR
// controller). A grant is sticky: the owner keeps the port for as long as it
// holds its request, so multi-word line fills and write-through drains are
// never interleaved. With MAX_XFERS != 0 the owner is forced out on its
// MAX_XFERS-th acked transfer if another master is waiting.
//
// Ports
//   clk_i, rst_i   clock, synchronous active-high reset
//   s_req          per-master request, held until acked
//   s_addr         packed addresses, master i at [i*BE_ADDR_W +: BE_ADDR_W]
//   s_wdata        packed write data
//   s_wstrb        packed byte strobes (all-zero = read)
//   s_rdata        m_rdata replicated into every slot
//   s_ack          per-master acknowledge (one-hot or zero)
//   m_req/m_addr/m_wdata/m_wstrb   request towards memory
//   m_rdata/m_ack                  response from memory
// -----------------------------------------------------------------------------
module iob_cache_be_arbiter #(
    parameter int N_MASTERS = 2,
    parameter int BE_ADDR_W = 24,
    parameter int BE_DATA_W = 32,
    parameter int MAX_XFERS = 8
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [N_MASTERS-1:0]              s_req,
    input  logic [N_MASTERS*BE_ADDR_W-1:0]    s_addr,
    input  logic [N_MASTERS*BE_DATA_W-1:0]    s_wdata,
    input  logic [N_MASTERS*BE_DATA_W/8-1:0]  s_wstrb,
    output logic [N_MASTERS*BE_DATA_W-1:0]    s_rdata,
    output logic [N_MASTERS-1:0]              s_ack,
    output logic                              m_req,
    output logic [BE_ADDR_W-1:0]              m_addr,
    output logic [BE_DATA_W-1:0]              m_wdata,
    output logic [BE_DATA_W/8-1:0]            m_wstrb,
    input  logic [BE_DATA_W-1:0]              m_rdata,
    input  logic                              m_ack
);

    localparam int STRB_W = BE_DATA_W / 8;
    localparam int IDX_W  = $clog2(N_MASTERS);
    localparam int CNT_W  = (MAX_XFERS > 0) ? $clog2(MAX_XFERS + 1) : 1;

    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(N_MASTERS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_XFERS);
    localparam logic [CNT_W-1:0] CNT_CAP  = CNT_W'(MAX_XFERS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] last_q,  last_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    logic             pick_vld;
    logic [IDX_W-1:0] pick_idx;
    logic             owner_req;
    logic             others_req;
    logic             xfer;
    logic             force_out;

    // -------------------------------------------------------------------------
    // Round-robin search starting just after the previous owner, so the
    // master that last held the port is the lowest priority this round.
    // -------------------------------------------------------------------------
    // NOTE: every variable of a combinational block gets a default before any
    // branch; a path that leaves one unassigned would infer a latch.
    always_comb begin
        logic [IDX_W-1:0] idx;
        pick_vld = 1'b0;
        pick_idx = '0;
        idx      = '0;
        for (int k = 1; k <= N_MASTERS; k++) begin
            idx = IDX_W'((int'(last_q) + k) % N_MASTERS);
            if (!pick_vld && s_req[idx]) begin
                pick_vld = 1'b1;
                pick_idx = idx;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Forwarding. Address and data always come from the grant slot; only the
    // strobe is masked in IDLE so nothing looks like a write between grants.
    // m_req and s_ack are also held low while rst_i is asserted so the port
    // goes quiet in the reset cycle itself.
    // -------------------------------------------------------------------------
    always_comb begin
        logic [N_MASTERS-1:0] grant_oh;
        grant_oh           = '0;
        grant_oh[grant_q]  = 1'b1;

        owner_req  = s_req[grant_q];
        others_req = |(s_req & ~grant_oh);

        m_req   = (state_q == BUSY) && owner_req && !rst_i;
        m_addr  = s_addr [int'(grant_q)*BE_ADDR_W +: BE_ADDR_W];
        m_wdata = s_wdata[int'(grant_q)*BE_DATA_W +: BE_DATA_W];
        m_wstrb = (state_q == BUSY) ? s_wstrb[int'(grant_q)*STRB_W +: STRB_W]
                                    : '0;

        // m_ack is only meaningful while m_req is high.
        xfer           = m_req && m_ack;
        s_ack          = '0;
        s_ack[grant_q] = xfer;
        s_rdata        = {N_MASTERS{m_rdata}};

        // Forced release fires on the capping ack itself; that ack is still
        // delivered to the owner this cycle.
        force_out = (MAX_XFERS != 0) && xfer && (cnt_q == CNT_CAP) && others_req;
    end

    // -------------------------------------------------------------------------
    // Next-state logic.
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    grant_d = pick_idx;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                // Saturates at the cap so a lone owner keeps streaming.
                if (xfer && (MAX_XFERS != 0) && (cnt_q != CNT_MAX)) begin
                    cnt_d = cnt_q + 1'b1;
                end
                // A dropped request means no transfer is outstanding, since
                // the native protocol holds req until ack.
                if (!owner_req || force_out) begin
                    state_d = IDLE;
                    last_d  = grant_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours, independent of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= LAST_RST;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_iob_cache_be_arbiter.sv
// -----------------------------------------------------------------------------
// Directed bench for iob_cache_be_arbiter. Two instances: dut_cap8
// (MAX_XFERS=8) for the sticky-grant scenarios and dut_cap2 (MAX_XFERS=2) for
// the forced-handover and saturation scenarios. Each instance has a small
// memory model (ack after wait_cyc cycles of m_req) and a per-master model
// (word count, address stepping by 4).
// -----------------------------------------------------------------------------
module tb_iob_cache_be_arbiter;

    localparam int AW = 24;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    typedef struct {
        int owner;
        int addr;
        int cnt;
        int cyc;
    } ev_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]                 rst;
    logic [1:0][1:0]            s_req;
    logic [1:0][2*AW-1:0]       s_addr;
    logic [1:0][2*DW-1:0]       s_wdata;
    logic [1:0][2*SW-1:0]       s_wstrb;
    logic [1:0][2*DW-1:0]       s_rdata;
    logic [1:0][1:0]            s_ack;
    logic [1:0]                 m_req;
    logic [1:0][AW-1:0]         m_addr;
    logic [1:0][DW-1:0]         m_wdata;
    logic [1:0][SW-1:0]         m_wstrb;
    logic [1:0][DW-1:0]         rdata_val;
    logic [1:0]                 m_ack;

    int wait_cyc [2];
    int wcnt     [2];

    assign m_ack = {m_req[1] && (wcnt[1] == wait_cyc[1]),
                    m_req[0] && (wcnt[0] == wait_cyc[0])};

    iob_cache_be_arbiter #(
        .N_MASTERS(2), .BE_ADDR_W(AW), .BE_DATA_W(DW), .MAX_XFERS(8)
    ) dut_cap8 (
        .clk_i(clk), .rst_i(rst[0]),
        .s_req(s_req[0]), .s_addr(s_addr[0]), .s_wdata(s_wdata[0]),
        .s_wstrb(s_wstrb[0]), .s_rdata(s_rdata[0]), .s_ack(s_ack[0]),
        .m_req(m_req[0]), .m_addr(m_addr[0]), .m_wdata(m_wdata[0]),
        .m_wstrb(m_wstrb[0]), .m_rdata(rdata_val[0]), .m_ack(m_ack[0])
    );

    iob_cache_be_arbiter #(
        .N_MASTERS(2), .BE_ADDR_W(AW), .BE_DATA_W(DW), .MAX_XFERS(2)
    ) dut_cap2 (
        .clk_i(clk), .rst_i(rst[1]),
        .s_req(s_req[1]), .s_addr(s_addr[1]), .s_wdata(s_wdata[1]),
        .s_wstrb(s_wstrb[1]), .s_rdata(s_rdata[1]), .s_ack(s_ack[1]),
        .m_req(m_req[1]), .m_addr(m_addr[1]), .m_wdata(m_wdata[1]),
        .m_wstrb(m_wstrb[1]), .m_rdata(rdata_val[1]), .m_ack(m_ack[1])
    );

    // Master models: words left, current address, strobe.
    int            rem    [2][2];
    logic [AW-1:0] addr_m [2][2];
    logic [SW-1:0] strb_m [2][2];

    int  total = 0;
    int  bad   = 0;
    int  cyc   = 0;
    ev_t log_q [$];

    logic          obs_req;
    logic [1:0]    obs_ack;
    logic [AW-1:0] obs_addr;
    logic [SW-1:0] obs_strb;
    logic [DW-1:0] obs_wdata;
    logic [2*DW-1:0] obs_rdata;
    int            obs_cnt;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] exp_wdata(input logic [AW-1:0] a, input int i);
        return {8'(i) ^ 8'hC3, a};
    endfunction

    task automatic drive(input int k);
        for (int i = 0; i < 2; i++) begin
            s_req[k][i]              = (rem[k][i] > 0);
            s_addr[k][i*AW +: AW]    = addr_m[k][i];
            s_wdata[k][i*DW +: DW]   = exp_wdata(addr_m[k][i], i);
            s_wstrb[k][i*SW +: SW]   = strb_m[k][i];
        end
    endtask

    // One clock of instance k: sample at negedge, advance the models on what
    // was acked, apply the new inputs just after the posedge.
    task automatic tick(input int k);
        logic ack_now;
        int   nw;
        @(negedge clk);
        cyc++;
        obs_req   = m_req[k];
        obs_ack   = s_ack[k];
        obs_addr  = m_addr[k];
        obs_strb  = m_wstrb[k];
        obs_wdata = m_wdata[k];
        obs_rdata = s_rdata[k];
        obs_cnt   = (k == 0) ? int'(dut_cap8.cnt_q) : int'(dut_cap2.cnt_q);
        ack_now   = m_ack[k];
        check("ack_onehot0", 64'($onehot0(obs_ack)), 64'd1);
        check("ack_without_req", 64'((obs_ack != 2'b00) && !obs_req), 64'd0);
        for (int i = 0; i < 2; i++) begin
            if (obs_ack[i]) begin
                check("ack_addr",  64'(obs_addr),  64'(addr_m[k][i]));
                check("ack_wstrb", 64'(obs_strb),  64'(strb_m[k][i]));
                check("ack_wdata", 64'(obs_wdata), 64'(exp_wdata(addr_m[k][i], i)));
                log_q.push_back('{i, int'(obs_addr), obs_cnt, cyc});
                rem[k][i]--;
                addr_m[k][i] += AW'(4);
            end
        end
        nw = (obs_req && !ack_now) ? wcnt[k] + 1 : 0;
        @(posedge clk);
        #1;
        wcnt[k] = nw;
        drive(k);
    endtask

    task automatic run_done(input int k, input int budget);
        int n = 0;
        while ((rem[k][0] > 0 || rem[k][1] > 0) && n < budget) begin
            tick(k);
            n++;
        end
        check("done_in_budget", 64'(n < budget), 64'd1);
        tick(k);
        tick(k);
    endtask

    task automatic check_log(input string tag, input int idx, input int owner,
                             input int addr, input int dcyc);
        if (idx >= log_q.size()) begin
            check({tag, "_missing"}, 64'(log_q.size()), 64'(idx + 1));
        end else begin
            check({tag, "_owner"}, 64'(log_q[idx].owner), 64'(owner));
            check({tag, "_addr"},  64'(log_q[idx].addr),  64'(addr));
            check({tag, "_cyc"},   64'(log_q[idx].cyc - log_q[0].cyc), 64'(dcyc));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t3_addr [5];
        int t4_own  [6];
        int t4_addr [6];
        int t4_dc   [6];
        int t4_cnt  [6];
        int t5_cnt  [6];
        t3_addr = '{32'h200, 32'h204, 32'h208, 32'h20C, 32'h500};
        t4_own  = '{0, 0, 1, 0, 0, 0};
        t4_addr = '{32'h600, 32'h604, 32'h700, 32'h608, 32'h60C, 32'h610};
        t4_dc   = '{0, 1, 3, 6, 7, 8};
        t4_cnt  = '{0, 1, 0, 0, 1, 2};
        t5_cnt  = '{0, 1, 2, 2, 2, 2};

        rst = 2'b11;
        for (int k = 0; k < 2; k++) begin
            wait_cyc[k] = 0;
            wcnt[k]     = 0;
            rdata_val[k] = '0;
            for (int i = 0; i < 2; i++) begin
                rem[k][i]    = 0;
                addr_m[k][i] = '0;
                strb_m[k][i] = '0;
            end
            drive(k);
        end

        // Reset state.
        tick(0);
        tick(0);
        check("rst_mreq", 64'(obs_req), 64'd0);
        check("rst_sack", 64'(obs_ack), 64'd0);
        rst = 2'b00;
        tick(0);
        check("idle_mreq",  64'(obs_req),  64'd0);
        check("idle_wstrb", 64'(obs_strb), 64'd0);
        check("idle_addr",  64'(obs_addr), 64'd0);

        // Test 1: lone read from master 1, memory waits 2 cycles.
        wait_cyc[0]  = 2;
        rdata_val[0] = 32'hDEAD_BEEF;
        rem[0][1]    = 1;
        addr_m[0][1] = 24'h100;
        drive(0);
        tick(0);
        check("t1_idle_cycle", 64'(obs_req), 64'd0);
        tick(0);
        check("t1_req",   64'(obs_req),  64'd1);
        check("t1_addr",  64'(obs_addr), 64'h100);
        check("t1_noack", 64'(obs_ack),  64'd0);
        tick(0);
        check("t1_wait", 64'(obs_ack), 64'd0);
        tick(0);
        check("t1_ack",    64'(obs_ack), 64'b10);
        check("t1_rdata1", 64'(obs_rdata[63:32]), 64'hDEAD_BEEF);
        check("t1_rdata0", 64'(obs_rdata[31:0]),  64'hDEAD_BEEF);
        tick(0);
        check("t1_release", 64'(obs_req), 64'd0);
        tick(0);

        // Test 2: simultaneous requests right after reset; master 0 first.
        rst[0] = 1'b1;
        tick(0);
        rst[0] = 1'b0;
        wait_cyc[0]  = 0;
        rem[0][0]    = 1;
        addr_m[0][0] = 24'h300;
        rem[0][1]    = 1;
        addr_m[0][1] = 24'h400;
        drive(0);
        tick(0);
        check("t2_idle", 64'(obs_req), 64'd0);
        tick(0);
        check("t2_ack0",  64'(obs_ack),  64'b01);
        check("t2_addr0", 64'(obs_addr), 64'h300);
        tick(0);
        check("t2_drop",   64'(obs_req), 64'd0);
        tick(0);
        check("t2_bubble", 64'(obs_req), 64'd0);
        tick(0);
        check("t2_ack1",  64'(obs_ack),  64'b10);
        check("t2_addr1", 64'(obs_addr), 64'h400);
        tick(0);
        tick(0);

        // Test 3: 4-word line fill by master 0, master 1 joins at word 2.
        log_q.delete();
        rem[0][0]    = 4;
        addr_m[0][0] = 24'h200;
        drive(0);
        tick(0);
        tick(0);
        rem[0][1]    = 1;
        addr_m[0][1] = 24'h500;
        drive(0);
        run_done(0, 40);
        check("t3_count", 64'(log_q.size()), 64'd5);
        for (int j = 0; j < 4; j++) check_log("t3_fill", j, 0, t3_addr[j], j);
        check_log("t3_after", 4, 1, t3_addr[4], 6);

        // Test 4: cap of 2, master 0 five words (writes), master 1 one read.
        log_q.delete();
        wait_cyc[1]  = 0;
        rem[1][0]    = 5;
        addr_m[1][0] = 24'h600;
        strb_m[1][0] = 4'hF;
        rem[1][1]    = 1;
        addr_m[1][1] = 24'h700;
        drive(1);
        run_done(1, 60);
        check("t4_count", 64'(log_q.size()), 64'd6);
        for (int j = 0; j < 6; j++) begin
            check_log("t4_seq", j, t4_own[j], t4_addr[j], t4_dc[j]);
            if (j < log_q.size()) check("t4_cnt", 64'(log_q[j].cnt), 64'(t4_cnt[j]));
        end

        // Test 5: cap of 2, lone master streams six words, counter saturates.
        log_q.delete();
        rem[1][0]    = 6;
        addr_m[1][0] = 24'h800;
        strb_m[1][0] = 4'h0;
        drive(1);
        run_done(1, 40);
        check("t5_count", 64'(log_q.size()), 64'd6);
        for (int j = 0; j < 6; j++) begin
            check_log("t5_seq", j, 0, 32'h800 + 4 * j, j);
            if (j < log_q.size()) check("t5_cnt", 64'(log_q[j].cnt), 64'(t5_cnt[j]));
        end
        check("t5_cnt_final", 64'(dut_cap2.cnt_q), 64'd2);

        // Test 6: reset while master 1 owns the port with m_req high.
        log_q.delete();
        wait_cyc[0]  = 10;
        rem[0][1]    = 1;
        addr_m[0][1] = 24'h900;
        drive(0);
        tick(0);
        check("t6_idle", 64'(obs_req), 64'd0);
        tick(0);
        check("t6_busy_req",  64'(obs_req),  64'd1);
        check("t6_busy_addr", 64'(obs_addr), 64'h900);
        rst[0] = 1'b1;
        tick(0);
        check("t6_rst_sack", 64'(obs_ack), 64'd0);
        rst[0]       = 1'b0;
        wait_cyc[0]  = 0;
        rem[0][0]    = 1;
        addr_m[0][0] = 24'hA00;
        drive(0);
        tick(0);
        check("t6_post_req",   64'(obs_req),  64'd0);
        check("t6_post_sack",  64'(obs_ack),  64'd0);
        check("t6_post_wstrb", 64'(obs_strb), 64'd0);
        tick(0);
        check("t6_win0", 64'(obs_ack), 64'b01);
        run_done(0, 40);
        check("t6_count", 64'(log_q.size()), 64'd2);
        check_log("t6_first",  0, 0, 32'hA00, 0);
        check_log("t6_second", 1, 1, 32'h900, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
